xpb_seq_ctrl: RTL

Time-multiplexed sequencer for the xpb weighting datapath.
- Computes flag * xpb_prime[i] for all NUM_XPB limbs using only NUM_LANES shared 27x18 multipliers instead of one per limb.
- Splits each product into a 27b low part (xpb0) and an 18b high part (xpb1). The high part is shifted up one limb position so both arrays feed the adder tree directly.
- Sits between the modular-squaring control FSM (requester) and the reduction adder tree (consumer). Uses valid/ready handshakes on both sides.

---
 rtl/xpb_pkg.sv | 25 ++
 rtl/multiplier_27_18.sv | 8 +
 rtl/xpb_lane_mux.sv | 29 ++
 rtl/xpb_seq_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/xpb_pkg.sv
// Shared sizes, types and FSM encoding for the xpb weighting sequencer.
package xpb_pkg;
  localparam int BIT_LEN_FLAG = 18;
  localparam int BIT_LEN_XPB  = 27;
  localparam int NUM_XPB      = 38;
  localparam int NUM_LANES    = 4;
  localparam int PASSES       = (NUM_XPB + NUM_LANES - 1) / NUM_LANES;
  localparam int GRP_W        = $clog2(PASSES + 1);
  localparam int PROD_W       = BIT_LEN_XPB + BIT_LEN_FLAG;

  typedef logic [BIT_LEN_XPB-1:0]  limb_t;
  typedef logic [BIT_LEN_FLAG-1:0] flag_t;
  typedef logic [PROD_W-1:0]       prod_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  function automatic int passes_for(input int lanes);
    return (NUM_XPB + lanes - 1) / lanes;
  endfunction
endpackage

// File: rtl/multiplier_27_18.sv
// Unsigned 27x18 multiplier cell, combinational, full 45b product.
module multiplier_27_18 (
  input  logic [26:0] i_a,
  input  logic [17:0] i_b,
  output logic [44:0] o_p
);
  assign o_p = {18'b0, i_a} * {27'b0, i_b};
endmodule

// File: rtl/xpb_lane_mux.sv
// Picks the limb operands for the current issue group; combinational, no flow control.
// Lanes that fall past the last limb get a zero operand and a cleared valid bit.
module xpb_lane_mux
  import xpb_pkg::*;
#(
  parameter int LANES = NUM_LANES,
  parameter int PASS  = PASSES,
  parameter int GW    = GRP_W
) (
  input  logic [GW-1:0]    i_grp,
  input  limb_t            i_tbl [NUM_XPB],
  output limb_t            o_op  [LANES],
  output logic [LANES-1:0] o_vld
);
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      o_op[k]  = '0;
      o_vld[k] = 1'b0;
    end
    for (int g = 0; g < PASS; g++) begin
      for (int k = 0; k < LANES; k++) begin
        if ((g * LANES + k < NUM_XPB) && (i_grp == GW'(g))) begin
          o_op[k]  = i_tbl[(g * LANES + k < NUM_XPB) ? (g * LANES + k) : 0];
          o_vld[k] = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/xpb_seq_ctrl.sv
// Time-multiplexed flag*xpb_prime sequencer; result valid PASSES+1 edges after request.
// One request at a time: req_ready only in IDLE, results held until res_ready.
module xpb_seq_ctrl
  import xpb_pkg::*;
#(
  parameter int NUM_LANES_P = NUM_LANES
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic [BIT_LEN_FLAG-1:0] i_req_flag,
  input  limb_t                   i_xpb_prime [NUM_XPB],
  output logic                    o_busy,
  output logic                    o_res_valid,
  input  logic                    i_res_ready,
  output limb_t                   o_res_xpb0 [NUM_XPB],
  output limb_t                   o_res_xpb1 [NUM_XPB],
  output logic [BIT_LEN_FLAG-1:0] o_res_carry
);
  localparam int PASS = passes_for(NUM_LANES_P);
  localparam int GW   = $clog2(PASS + 1);

  state_e                 r_state;
  state_e                 w_state_nxt;
  flag_t                  r_flag;
  logic [GW-1:0]          r_grp;
  logic                   r_stg_vld;
  logic [GW-1:0]          r_stg_grp;
  logic [NUM_LANES_P-1:0] r_stg_lv;
  prod_t                  r_stg_prod [NUM_LANES_P];
  limb_t                  r_xpb0 [NUM_XPB];
  limb_t                  r_xpb1 [NUM_XPB];
  flag_t                  r_carry;
  logic                   r_res_vld;

  limb_t                  w_op   [NUM_LANES_P];
  logic [NUM_LANES_P-1:0] w_lv;
  prod_t                  w_prod [NUM_LANES_P];
  logic [NUM_XPB-1:0]     w_wr;
  limb_t                  w_lo [NUM_XPB];
  flag_t                  w_hi [NUM_XPB];

  xpb_lane_mux #(
    .LANES (NUM_LANES_P),
    .PASS  (PASS),
    .GW    (GW)
  ) u_lane_mux (
    .i_grp (r_grp),
    .i_tbl (i_xpb_prime),
    .o_op  (w_op),
    .o_vld (w_lv)
  );

  for (genvar k = 0; k < NUM_LANES_P; k++) begin : g_lane
    multiplier_27_18 u_mul (
      .i_a (w_op[k]),
      .i_b (r_flag),
      .o_p (w_prod[k])
    );
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (i_req_valid) w_state_nxt = ST_RUN;
      ST_RUN:   if (r_grp == GW'(PASS - 1)) w_state_nxt = ST_DRAIN;
      ST_DRAIN: w_state_nxt = ST_HOLD;
      ST_HOLD:  if (r_res_vld && i_res_ready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = (r_state == ST_IDLE);
    o_busy      = (r_state != ST_IDLE);
  end

  // Limb i lives in lane i%L of group i/L; the stage carries group g into the arrays one edge later.
  always_comb begin
    for (int i = 0; i < NUM_XPB; i++) begin
      w_wr[i] = r_stg_vld && r_stg_lv[i % NUM_LANES_P] &&
                (r_stg_grp == GW'(i / NUM_LANES_P));
      w_lo[i] = r_stg_prod[i % NUM_LANES_P][BIT_LEN_XPB-1:0];
      w_hi[i] = r_stg_prod[i % NUM_LANES_P][PROD_W-1:BIT_LEN_XPB];
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_flag     <= '0;
      r_grp      <= '0;
      r_stg_vld  <= 1'b0;
      r_stg_grp  <= '0;
      r_stg_lv   <= '0;
      r_stg_prod <= '{default: '0};
    end else begin
      if (r_state == ST_IDLE && i_req_valid) begin
        r_flag <= i_req_flag;
        r_grp  <= '0;
      end
      r_stg_vld <= (r_state == ST_RUN);
      if (r_state == ST_RUN) begin
        r_grp      <= r_grp + GW'(1);
        r_stg_grp  <= r_grp;
        r_stg_lv   <= w_lv;
        r_stg_prod <= w_prod;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_xpb0  <= '{default: '0};
      r_xpb1  <= '{default: '0};
      r_carry <= '0;
    end else begin
      for (int i = 0; i < NUM_XPB; i++) begin
        if (w_wr[i]) r_xpb0[i] <= w_lo[i];
      end
      // High part of limb j-1 lands one position up; slot 0 is never written.
      for (int j = 1; j < NUM_XPB; j++) begin
        if (w_wr[j-1]) r_xpb1[j] <= limb_t'(w_hi[j-1]);
      end
      if (w_wr[NUM_XPB-1]) r_carry <= w_hi[NUM_XPB-1];
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                                   r_res_vld <= 1'b0;
    else if (r_state == ST_DRAIN)                  r_res_vld <= 1'b1;
    else if (r_state == ST_HOLD && i_res_ready)    r_res_vld <= 1'b0;
  end

  assign o_res_valid = r_res_vld;
  assign o_res_xpb0  = r_xpb0;
  assign o_res_xpb1  = r_xpb1;
  assign o_res_carry = r_carry;
endmodule
